// File: rtl/sum_accum_pkg.sv
// sum_accum_pkg
//   Shared definitions for the sum_accum block.
//   - state_t   : block state (IDLE = nothing accumulated, ACCUM = partial
//                 block in acc, HOLD = finished result presented downstream)
//   - sat_bound : signed max/min of a w-bit two's complement type, returned
//                 zero/sign-extended in a wide vector; callers truncate it to
//                 their own data type.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int BOUND_W = 256;

  function automatic logic [BOUND_W-1:0] sat_bound(input int w, input logic want_min);
    logic [BOUND_W-1:0] mx;
    mx = (BOUND_W'(1) << (w - 1)) - BOUND_W'(1);
    // -2**(w-1) is the bitwise complement of 2**(w-1)-1 in two's complement.
    return want_min ? ~mx : mx;
  endfunction

endpackage

// File: rtl/sum_accum_add_type.sv
// add_type
//   Plain two-operand adder on a parameterised signed data type. The sum wraps
//   modulo 2**$bits(DTYPE); overflow handling is left to the instantiating
//   block, which sees both operands and the result.
// Ports:
//   a, b : operands (DTYPE)
//   sum  : a + b, wrapped (DTYPE)
module add_type #(
  parameter type DTYPE = logic signed [15:0]
) (
  input  DTYPE a,
  input  DTYPE b,
  output DTYPE sum
);

  assign sum = a + b;

endmodule

// File: rtl/sum_accum.sv
// sum_accum
//   Sums N consecutive accepted input samples into one result and presents it
//   with a valid/ready handshake. While a result is held, input is back-
//   pressured, except in the cycle the result is taken, when a new sample may
//   start the next block (one result per N cycles sustained).
//   out_ovf is the sticky OR of signed overflow over the adds of the block.
//
//   Build option: define SUM_ACCUM_SATURATE_EN to clamp overflowing adds to the
//   DTYPE signed max/min instead of wrapping. Ports are identical either way.
//
// Parameters:
//   DTYPE : signed integral data type of data ports and accumulator
//   N     : samples per result (2..256)
// Ports:
//   clk       : clock, rising edge
//   rstN      : asynchronous active-low reset
//   in_valid  : in_data valid
//   in_ready  : block accepts in_data this cycle
//   in_data   : input sample
//   out_valid : out_data holds a completed result
//   out_ready : downstream accepts out_data
//   out_data  : accumulated result
//   out_ovf   : an add in this result overflowed DTYPE
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter type DTYPE = logic signed [15:0],
  parameter int  N     = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic in_valid,
  output logic in_ready,
  input  DTYPE in_data,
  output logic out_valid,
  input  logic out_ready,
  output DTYPE out_data,
  output logic out_ovf
);

  localparam int W  = $bits(DTYPE);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nxt;
  DTYPE          acc;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          rdy_en;

  logic          take;
  logic          load_first;
  logic          load_add;
  logic          clear_cnt;

  DTYPE          add_sum;
  DTYPE          acc_add;
  logic          add_ovf;

  add_type #(.DTYPE(DTYPE)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum)
  );

  // Signed overflow: operands agree in sign, wrapped result does not.
  assign add_ovf = (acc[W-1] == in_data[W-1]) && (add_sum[W-1] != acc[W-1]);

`ifdef SUM_ACCUM_SATURATE_EN
  // Clamp toward the overflow direction; both operands share acc's sign.
  function automatic DTYPE clamp(input DTYPE s, input logic o, input logic neg);
    if (o) return DTYPE'(sat_bound(W, neg));
    return s;
  endfunction

  assign acc_add = clamp(add_sum, add_ovf, acc[W-1]);
`else
  assign acc_add = add_sum;
`endif

  // rdy_en keeps in_ready low during reset and for the rest of the cycle in
  // which reset is released; it rises on the first clock edge afterwards.
  assign in_ready  = rdy_en && ((state != HOLD) || out_ready);
  assign take      = in_valid && in_ready;
  assign out_data  = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_add   = 1'b0;
    clear_cnt  = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nxt  = ACCUM;
          load_first = 1'b1;
        end
      end
      ACCUM: begin
        if (take) begin
          load_add = 1'b1;
          if (cnt == LAST) state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (take) begin
            state_nxt  = ACCUM;
            load_first = 1'b1;
          end else begin
            state_nxt  = IDLE;
            clear_cnt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- accumulate stage: acc/cnt/ovf update on accepted samples ----
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc    <= DTYPE'(0);
      cnt    <= '0;
      ovf    <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (load_first) begin
        acc <= in_data;
        cnt <= CW'(1);
        ovf <= 1'b0;
      end else if (load_add) begin
        acc <= acc_add;
        cnt <= cnt + CW'(1);
        ovf <= ovf | add_ovf;
      end else if (clear_cnt) begin
        cnt <= '0;
      end
    end
  end

endmodule
